random_seq_checker: RTL and testbench

- Receive-side checker for the 4-bit pseudo-random sequence generator: 0,1,6,8,9,13,14,11,4, then wrap to 0.
- Samples a qualified 4-bit symbol stream and locks onto the sequence phase.
- Once locked, checks every symbol against its expected successor, flags mismatches and counts errors.
- Sits at the far end of a link driven by the generator; used as a link/self-test monitor.

---
 rtl/random_seq_pkg.sv | 42 ++++
 rtl/random_seq_succ.sv | 16 +
 rtl/random_seq_checker.sv | 145 ++++++++++++++
 tb/tb_random_seq_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/random_seq_pkg.sv
// Shared types and the successor table for the 9-symbol pseudo-random sequence
// 0,1,6,8,9,13,14,11,4 (wrapping back to 0).
package random_seq_pkg;

    localparam int SEQ_LEN = 9;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] succ;
    } succ_entry_t;

    // Indexed by symbol value; symbols outside the sequence carry legal=0.
    localparam succ_entry_t SUCC_TABLE [16] = '{
        '{1'b1, 4'd1},
        '{1'b1, 4'd6},
        '{1'b0, 4'd0},
        '{1'b0, 4'd0},
        '{1'b1, 4'd0},
        '{1'b0, 4'd0},
        '{1'b1, 4'd8},
        '{1'b0, 4'd0},
        '{1'b1, 4'd9},
        '{1'b1, 4'd13},
        '{1'b0, 4'd0},
        '{1'b1, 4'd4},
        '{1'b0, 4'd0},
        '{1'b1, 4'd14},
        '{1'b1, 4'd11},
        '{1'b0, 4'd0}
    };

    function automatic succ_entry_t succ_lookup(input logic [3:0] sym);
        return SUCC_TABLE[sym];
    endfunction

endpackage

// File: rtl/random_seq_succ.sv
// Combinational successor lookup: symbol in, {legal, successor} out.
module random_seq_succ
    import random_seq_pkg::*;
(
    input  logic [3:0] i_sym,
    output logic       o_legal,
    output logic [3:0] o_succ
);

    succ_entry_t w_entry;

    assign w_entry = succ_lookup(i_sym);
    assign o_legal = w_entry.legal;
    assign o_succ  = w_entry.succ;

endmodule

// File: rtl/random_seq_checker.sv
// Receive-side checker: locks onto the pseudo-random symbol sequence, then
// flags and counts mismatches, flywheeling through isolated errors.
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | waiting for any legal symbol to seed the expected successor
// VERIFY | counting consecutive correct successors toward lock
// LOCKED | checking every symbol; UNLOCK_CNT misses in a row drop lock
module random_seq_checker
    import random_seq_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [3:0]       din,
    input  logic             clr_err,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       expected
);

    localparam logic [3:0] LOCK_TC   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TC = 4'(UNLOCK_CNT);

    state_t           r_state;
    logic [3:0]       r_exp;
    logic [3:0]       r_good_cnt;
    logic [3:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_match;
    logic             w_use_din;
    logic [3:0]       w_succ_in;
    logic             w_legal;
    logic [3:0]       w_succ;
    logic [3:0]       w_good_nxt;
    logic [3:0]       w_miss_nxt;
    logic             w_err_inc;

    assign w_match    = (din == r_exp);
    // Seed from the received symbol while hunting or reseeding; otherwise
    // advance from our own expectation so the flywheel ignores bad symbols.
    assign w_use_din  = (r_state == HUNT) || ((r_state == VERIFY) && !w_match);
    assign w_succ_in  = w_use_din ? din : r_exp;
    assign w_good_nxt = r_good_cnt + 4'd1;
    assign w_miss_nxt = r_miss_cnt + 4'd1;
    assign w_err_inc  = din_valid && (r_state == LOCKED) && !w_match;

    random_seq_succ u_succ (
        .i_sym   (w_succ_in),
        .o_legal (w_legal),
        .o_succ  (w_succ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_exp      <= 4'd0;
            r_good_cnt <= 4'd0;
            r_miss_cnt <= 4'd0;
            r_locked   <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_seq_err <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_legal) begin
                            r_exp      <= w_succ;
                            r_good_cnt <= 4'd0;
                            r_state    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (w_match) begin
                            r_exp      <= w_succ;
                            r_good_cnt <= w_good_nxt;
                            if (w_good_nxt == LOCK_TC) begin
                                r_state    <= LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= 4'd0;
                            end
                        end else if (w_legal) begin
                            r_exp      <= w_succ;
                            r_good_cnt <= 4'd0;
                        end else begin
                            r_state    <= HUNT;
                            r_exp      <= 4'd0;
                            r_good_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_miss_cnt <= 4'd0;
                            r_exp      <= w_succ;
                        end else begin
                            r_seq_err <= 1'b1;
                            if (w_miss_nxt == UNLOCK_TC) begin
                                r_state    <= HUNT;
                                r_locked   <= 1'b0;
                                r_exp      <= 4'd0;
                                r_good_cnt <= 4'd0;
                                r_miss_cnt <= 4'd0;
                            end else begin
                                r_miss_cnt <= w_miss_nxt;
                                r_exp      <= w_succ;
                            end
                        end
                    end
                    default: begin
                        r_state    <= HUNT;
                        r_exp      <= 4'd0;
                        r_good_cnt <= 4'd0;
                        r_miss_cnt <= 4'd0;
                        r_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear coinciding with a new error keeps that error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= w_err_inc ? ERR_W'(1) : '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign locked   = r_locked;
    assign seq_err  = r_seq_err;
    assign err_cnt  = r_err_cnt;
    assign expected = r_exp;

endmodule

// File: tb/tb_random_seq_checker.sv
// Scoreboard bench: directed symbol vectors push hand-computed expectations,
// a monitor pops and compares one entry per sampled cycle.
module tb_random_seq_checker;

    typedef struct {
        bit         b;
        logic       lk;
        logic       se;
        logic [7:0] ec;
        logic [3:0] ex;
        string      nm;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       a_valid, a_clr, b_valid, b_clr;
    logic [3:0] a_din, b_din;
    logic       a_locked, a_seq_err, b_locked, b_seq_err;
    logic [7:0] a_err_cnt;
    logic [1:0] b_err_cnt;
    logic [3:0] a_expected, b_expected;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    random_seq_checker dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (a_valid),
        .din       (a_din),
        .clr_err   (a_clr),
        .locked    (a_locked),
        .seq_err   (a_seq_err),
        .err_cnt   (a_err_cnt),
        .expected  (a_expected)
    );

    random_seq_checker #(.LOCK_CNT(3), .UNLOCK_CNT(15), .ERR_W(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (b_valid),
        .din       (b_din),
        .clr_err   (b_clr),
        .locked    (b_locked),
        .seq_err   (b_seq_err),
        .err_cnt   (b_err_cnt),
        .expected  (b_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input bit b, input logic v, input logic [3:0] d, input logic c,
                        input logic lk, input logic se, input logic [7:0] ec,
                        input logic [3:0] ex, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_clr   = 1'b0;
        b_valid = 1'b0;
        b_clr   = 1'b0;
        if (!b) begin
            a_valid = v;
            a_din   = d;
            a_clr   = c;
        end else begin
            b_valid = v;
            b_din   = d;
            b_clr   = c;
        end
        e.b  = b;
        e.lk = lk;
        e.se = se;
        e.ec = ec;
        e.ex = ex;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string nm);
        logic [14:0] act;
        act = {a_locked, a_seq_err, a_err_cnt, a_expected} |
              {b_locked, b_seq_err, 6'd0, b_err_cnt, b_expected};
        checks++;
        if (act !== 15'd0) begin
            errors++;
            $display("FAIL %s: actual a=%0d/%0d/%0d/%0d b=%0d/%0d/%0d/%0d required all 0",
                     nm, a_locked, a_seq_err, a_err_cnt, a_expected,
                     b_locked, b_seq_err, b_err_cnt, b_expected);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: actual %0d entries pending required 0", nm, sb.size());
        end
        #5;
    endtask

    initial begin : monitor
        exp_t       e;
        logic       lk, se;
        logic [7:0] ec;
        logic [3:0] ex;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                #2;
                if (!e.b) begin
                    lk = a_locked; se = a_seq_err; ec = a_err_cnt; ex = a_expected;
                end else begin
                    lk = b_locked; se = b_seq_err; ec = {6'd0, b_err_cnt}; ex = b_expected;
                end
                checks++;
                if ({lk, se, ec, ex} !== {e.lk, e.se, e.ec, e.ex}) begin
                    errors++;
                    $display("FAIL %s: actual lk=%0d se=%0d ec=%0d ex=%0d required lk=%0d se=%0d ec=%0d ex=%0d",
                             e.nm, lk, se, ec, ex, e.lk, e.se, e.ec, e.ex);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0; a_din = 4'd0; a_clr = 1'b0;
        b_valid = 1'b0; b_din = 4'd0; b_clr = 1'b0;
        #3;
        check_zero("reset_state");
        #19;
        rst_n = 1'b1;

        // lock-in
        step(0, 1, 4'd0,  0, 0, 0, 0, 4'd1,  "lock_0");
        step(0, 1, 4'd1,  0, 0, 0, 0, 4'd6,  "lock_1");
        step(0, 1, 4'd6,  0, 0, 0, 0, 4'd8,  "lock_6");
        step(0, 1, 4'd8,  0, 1, 0, 0, 4'd9,  "lock_8");
        // single error, flywheel
        step(0, 1, 4'd9,  0, 1, 0, 0, 4'd13, "fly_9");
        step(0, 1, 4'd13, 0, 1, 0, 0, 4'd14, "fly_13");
        step(0, 1, 4'd7,  0, 1, 1, 1, 4'd11, "fly_err7");
        step(0, 1, 4'd11, 0, 1, 0, 1, 4'd4,  "fly_11");
        step(0, 1, 4'd4,  0, 1, 0, 1, 4'd0,  "wrap_4");
        step(0, 1, 4'd0,  0, 1, 0, 1, 4'd1,  "adv_0");
        step(0, 1, 4'd1,  0, 1, 0, 1, 4'd6,  "adv_1");
        step(0, 1, 4'd6,  0, 1, 0, 1, 4'd8,  "adv_6");
        step(0, 1, 4'd8,  0, 1, 0, 1, 4'd9,  "adv_8");
        // loss of lock
        step(0, 1, 4'd2,  0, 1, 1, 2, 4'd13, "loss_1st");
        step(0, 1, 4'd2,  0, 0, 1, 3, 4'd0,  "loss_2nd");
        // hunt filtering and reseed
        step(0, 1, 4'd2,  0, 0, 0, 3, 4'd0,  "hunt_2");
        step(0, 1, 4'd3,  0, 0, 0, 3, 4'd0,  "hunt_3");
        step(0, 1, 4'd15, 0, 0, 0, 3, 4'd0,  "hunt_15");
        step(0, 1, 4'd4,  0, 0, 0, 3, 4'd0,  "hunt_seed4");
        step(0, 1, 4'd0,  0, 0, 0, 3, 4'd1,  "ver_0");
        step(0, 1, 4'd5,  0, 0, 0, 3, 4'd0,  "ver_illegal5");
        step(0, 1, 4'd9,  0, 0, 0, 3, 4'd13, "hunt_seed9");
        step(0, 1, 4'd6,  0, 0, 0, 3, 4'd8,  "ver_reseed6");
        step(0, 1, 4'd8,  0, 0, 0, 3, 4'd9,  "relock_8");
        step(0, 1, 4'd9,  0, 0, 0, 3, 4'd13, "relock_9");
        step(0, 1, 4'd13, 0, 1, 0, 3, 4'd14, "relock_13");
        step(0, 1, 4'd14, 0, 1, 0, 3, 4'd11, "relock_14");
        // valid gaps with garbage, wrap
        step(0, 1, 4'd11, 0, 1, 0, 3, 4'd4,  "gap_11");
        step(0, 0, 4'd7,  0, 1, 0, 3, 4'd4,  "gap_a");
        step(0, 1, 4'd4,  0, 1, 0, 3, 4'd0,  "gap_4");
        step(0, 0, 4'd15, 0, 1, 0, 3, 4'd0,  "gap_b");
        step(0, 1, 4'd0,  0, 1, 0, 3, 4'd1,  "gap_0");
        step(0, 0, 4'd2,  0, 1, 0, 3, 4'd1,  "gap_c");
        step(0, 1, 4'd1,  0, 1, 0, 3, 4'd6,  "gap_1");
        step(0, 0, 4'd5,  0, 1, 0, 3, 4'd6,  "gap_d");
        // err_cnt clear
        step(0, 0, 4'd5,  1, 1, 0, 0, 4'd6,  "clr_alone");
        step(0, 1, 4'd3,  1, 1, 1, 1, 4'd8,  "clr_with_err");
        step(0, 1, 4'd8,  0, 1, 0, 1, 4'd9,  "after_clr_8");
        step(0, 0, 4'd0,  0, 1, 0, 1, 4'd9,  "idle_a");
        // saturation on the 2-bit counter, long unlock threshold
        step(1, 1, 4'd0,  0, 0, 0, 0, 4'd1,  "b_lock_0");
        step(1, 1, 4'd1,  0, 0, 0, 0, 4'd6,  "b_lock_1");
        step(1, 1, 4'd6,  0, 0, 0, 0, 4'd8,  "b_lock_6");
        step(1, 1, 4'd8,  0, 1, 0, 0, 4'd9,  "b_lock_8");
        step(1, 1, 4'd2,  0, 1, 1, 1, 4'd13, "b_err1");
        step(1, 1, 4'd2,  0, 1, 1, 2, 4'd14, "b_err2");
        step(1, 1, 4'd2,  0, 1, 1, 3, 4'd11, "b_err3");
        step(1, 1, 4'd2,  0, 1, 1, 3, 4'd4,  "b_err4_sat");
        step(1, 1, 4'd4,  0, 1, 0, 3, 4'd0,  "b_match4");
        step(1, 0, 4'd0,  0, 1, 0, 3, 4'd0,  "b_idle");
        drain("scoreboard_drain");

        // async reset mid-LOCKED, observed before the next clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        #10;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
